// File: rtl/branch_redirect_unit_pkg.sv
// Purpose: shared types and constants for the branch redirect unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_redirect_unit_pkg;

   typedef enum logic [1:0] {
      BRU_RUN   = 2'd0,
      BRU_HOLD  = 2'd1,
      BRU_FLUSH = 2'd2
   } bru_state_t;

   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

   // Fetch is word-granular; low two address bits are dropped.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/branch_redirect_unit_if.sv
// Purpose: ID/hazard-side request bundle and fetch-side result bundle of the redirect unit.
// Latency: n/a (wiring only).
// Backpressure: stall from the hazard unit freezes the consumer; there is no ready signal.
//   master: drives stall, br_*, jmp_*; observes pc, flush_if, redirect_busy, misalign_err, counters.
//   slave : the redirect unit itself.
interface branch_redirect_unit_if #(
   parameter int CNT_W = 16
);
   logic             stall;
   logic             br_valid;
   logic             br_taken;
   logic [31:0]      br_target;
   logic             jmp_valid;
   logic [31:0]      jmp_target;
   logic [31:0]      pc;
   logic             flush_if;
   logic             redirect_busy;
   logic             misalign_err;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] taken_count;

   modport master (
      output stall, br_valid, br_taken, br_target, jmp_valid, jmp_target,
      input  pc, flush_if, redirect_busy, misalign_err, br_count, taken_count
   );

   modport slave (
      input  stall, br_valid, br_taken, br_target, jmp_valid, jmp_target,
      output pc, flush_if, redirect_busy, misalign_err, br_count, taken_count
   );
endinterface

// File: rtl/branch_redirect_unit_sat_counter.sv
// Purpose: saturating event counter (sat_counter); ports clk, rst_n, inc, clr, cnt.
// Latency: count visible one clk edge after inc/clr.
// Backpressure: none; sticks at all-ones instead of wrapping.
module branch_redirect_unit_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/branch_redirect_unit.sv
// Purpose: owns the fetch PC, redirects on taken branches/jumps, squashes IF/ID, counts branches.
// Latency: redirect lands on pc one edge after the accepting cycle; all outputs registered.
// Backpressure: stall freezes pc/state; a redirect seen under stall is parked and applied on release.
//   Ports: clk, rst_n, bus (slave modport of branch_redirect_unit_if).
module branch_redirect_unit
   import branch_redirect_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter bit          DELAY_SLOT   = 1'b0,
   parameter int          CNT_W        = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   branch_redirect_unit_if.slave bus
);

   bru_state_t  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic        flush_q, flush_d;
   logic        busy_q, busy_d;
   logic        mis_q, mis_d;

   logic        redir;
   logic [31:0] tgt_raw;
   logic [31:0] tgt;
   logic        accept;
   logic        br_inc;
   logic        tk_inc;

   // Jump wins over a simultaneous taken branch.
   assign redir   = bus.jmp_valid | (bus.br_valid & bus.br_taken);
   assign tgt_raw = bus.jmp_valid ? bus.jmp_target : bus.br_target;
   assign tgt     = align_word(tgt_raw);

   // ID inputs are consumed only in RUN: either normally, or when a redirect is parked under stall.
   // HOLD/FLUSH re-present or squash the same instruction, so it must not be counted again.
   assign accept = (state_q == BRU_RUN) & (~bus.stall | redir);
   assign br_inc = accept & bus.br_valid;
   assign tk_inc = accept & redir;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      busy_d  = busy_q;
      flush_d = 1'b0;
      mis_d   = accept & redir & (|tgt_raw[1:0]);
      case (state_q)
         BRU_RUN: begin
            if (!bus.stall) begin
               if (redir) begin
                  pc_d    = tgt;
                  flush_d = !DELAY_SLOT;
                  state_d = DELAY_SLOT ? BRU_RUN : BRU_FLUSH;
               end else begin
                  pc_d = pc_q + PC_STEP;
               end
            end else if (redir) begin
               pend_d  = tgt;
               busy_d  = 1'b1;
               state_d = BRU_HOLD;
            end
         end
         BRU_HOLD: begin
            if (!bus.stall) begin
               pc_d    = pend_q;
               busy_d  = 1'b0;
               flush_d = !DELAY_SLOT;
               state_d = DELAY_SLOT ? BRU_RUN : BRU_FLUSH;
            end
         end
         BRU_FLUSH: begin
            if (!bus.stall) begin
               pc_d    = pc_q + PC_STEP;
               state_d = BRU_RUN;
            end
         end
         default: state_d = BRU_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BRU_RUN;
         pc_q    <= RESET_VECTOR;
         pend_q  <= '0;
         flush_q <= 1'b0;
         busy_q  <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         flush_q <= flush_d;
         busy_q  <= busy_d;
         mis_q   <= mis_d;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.flush_if      = flush_q;
   assign bus.redirect_busy = busy_q;
   assign bus.misalign_err  = mis_q;

   branch_redirect_unit_sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (br_inc),
      .clr   (1'b0),
      .cnt   (bus.br_count)
   );

   branch_redirect_unit_sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (tk_inc),
      .clr   (1'b0),
      .cnt   (bus.taken_count)
   );

endmodule
